// File: rtl/mux3_rr_arbiter_pkg.sv
// mux3_rr_arbiter shared definitions.
// State encoding, select constants, round-robin helpers.
package mux3_rr_arbiter_pkg;

    localparam int NUM_REQ = 3;
    localparam int CNT_W   = 4;

    localparam logic [1:0] SEL_IDLE = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // (a + k) mod NUM_REQ for a in 0..2, k in 0..2
    function automatic logic [1:0] rr_add(
        input logic [1:0] a,
        input logic [1:0] k
    );
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, k};
        if (s >= 3'd3) begin
            s = s - 3'd3;
        end
        return s[1:0];
    endfunction

    // First valid requester scanning ptr, ptr+1, ptr+2.
    function automatic logic [1:0] rr_pick(
        input logic [1:0]         ptr,
        input logic [NUM_REQ-1:0] valid
    );
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = rr_add(ptr, 2'(k));
            if (!found && valid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [1:0] rr_next(input logic [1:0] g);
        return rr_add(g, 2'd1);
    endfunction

endpackage

// File: rtl/mux3_rr_arbiter_mux.sv
// degenerate_mux3to1: 3-input data mux with an idle select.
// Ports: sel (0..2 picks in0..in2, 3 gives zero), in0..in2, y.
module degenerate_mux3to1 #(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        unique case (sel)
            2'd0: y = in0;
            2'd1: y = in1;
            2'd2: y = in2;
            2'd3: y = '0;
        endcase
    end

endmodule

// File: rtl/mux3_rr_arbiter.sv
// mux3_rr_arbiter: round-robin burst arbiter over three requesters.
// Ports: clk, rst (sync, active-high); in0..in2 + req_valid/req_ready
// requester side; out_data/out_src/out_valid/out_ready output side;
// sel shows the current grant (3 = idle).
module mux3_rr_arbiter
    import mux3_rr_arbiter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BURST = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in0,
    input  logic [WIDTH-1:0]   in1,
    input  logic [WIDTH-1:0]   in2,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [1:0]         out_src,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [1:0]         sel
);

    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST);

    state_t           state;
    state_t           state_n;
    logic [1:0]       g;
    logic [1:0]       g_n;
    logic [1:0]       ptr;
    logic [1:0]       ptr_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [CNT_W-1:0] cnt_inc;

    logic [WIDTH-1:0]   mux_y;
    logic [NUM_REQ-1:0] g_onehot;
    logic               busy;
    logic               out_free;
    logic               xfer;
    logic               drop;
    logic               rel;

    assign busy     = (state == BUSY);
    assign sel      = busy ? g : SEL_IDLE;
    assign g_onehot = NUM_REQ'(1) << g;

    // Output register can take a word if empty or draining this cycle.
    assign out_free  = !out_valid || out_ready;
    assign req_ready = (busy && out_free) ? g_onehot : '0;

    assign xfer    = busy && req_valid[g] && req_ready[g];
    assign cnt_inc = cnt + CNT_W'(1);

    // Release on the last word of a burst or when the grantee goes quiet.
    assign drop = busy && !req_valid[g];
    assign rel  = drop || (xfer && (cnt_inc == BURST_LAST));

    degenerate_mux3to1 #(
        .WIDTH(WIDTH)
    ) u_mux (
        .sel(sel),
        .in0(in0),
        .in1(in1),
        .in2(in2),
        .y  (mux_y)
    );

    always_comb begin
        state_n = state;
        g_n     = g;
        ptr_n   = ptr;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (|req_valid) begin
                    state_n = BUSY;
                    g_n     = rr_pick(ptr, req_valid);
                    cnt_n   = '0;
                end
            end
            BUSY: begin
                if (rel) begin
                    state_n = IDLE;
                    ptr_n   = rr_next(g);
                    cnt_n   = '0;
                end else if (xfer) begin
                    cnt_n = cnt_inc;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            g     <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            g     <= g_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_src   <= '0;
            out_valid <= 1'b0;
        end else if (xfer) begin
            out_data  <= mux_y;
            out_src   <= g;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// tb_mux3_rr_arbiter: directed bench for mux3_rr_arbiter.
// Vector table plus hand sequences for burst/backpressure/release.
module tb_mux3_rr_arbiter;

    localparam logic [31:0] D0 = 32'h1111_0000;
    localparam logic [31:0] D1 = 32'hDEAD_BEEF;
    localparam logic [31:0] D2 = 32'h2222_0002;

    logic        clk;
    logic        rst;
    logic [31:0] in0;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [2:0]  req_valid;
    logic        out_ready;

    logic [2:0]  req_ready;
    logic [31:0] out_data;
    logic [1:0]  out_src;
    logic        out_valid;
    logic [1:0]  sel;

    logic [2:0]  b1_req_ready;
    logic [31:0] b1_out_data;
    logic [1:0]  b1_out_src;
    logic        b1_out_valid;
    logic [1:0]  b1_sel;

    int checks;
    int errors;

    mux3_rr_arbiter #(
        .WIDTH(32),
        .BURST(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in0      (in0),
        .in1      (in1),
        .in2      (in2),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .out_data (out_data),
        .out_src  (out_src),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sel      (sel)
    );

    mux3_rr_arbiter #(
        .WIDTH(32),
        .BURST(1)
    ) dut_b1 (
        .clk      (clk),
        .rst      (rst),
        .in0      (in0),
        .in1      (in1),
        .in2      (in2),
        .req_valid(req_valid),
        .req_ready(b1_req_ready),
        .out_data (b1_out_data),
        .out_src  (b1_out_src),
        .out_valid(b1_out_valid),
        .out_ready(out_ready),
        .sel      (b1_sel)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic [2:0]  rv;
        logic        ordy;
        logic [1:0]  e_sel;
        logic [2:0]  e_rdy;
        logic        e_ov;
        logic [31:0] e_od;
        logic [1:0]  e_src;
    } vec_t;

    vec_t tbl [11];

    logic [1:0] b1_exp   [8];
    logic [1:0] fair_exp [13];
    logic [1:0] src_log  [13];

    task automatic chk(
        input string       nm,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Two reset edges; returns #1 after the first post-reset negedge.
    task automatic do_reset();
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    function automatic logic [31:0] dsrc(input logic [1:0] s);
        logic [31:0] d;
        d = D2;
        if (s == 2'd0) d = D0;
        if (s == 2'd1) d = D1;
        return d;
    endfunction

    initial begin
        int n;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        req_valid = 3'b000;
        out_ready = 1'b1;
        in0       = D0;
        in1       = D1;
        in2       = D2;

        b1_exp   = '{2'd3, 2'd0, 2'd3, 2'd1, 2'd3, 2'd2, 2'd3, 2'd0};
        fair_exp = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1,
                     2'd2, 2'd2, 2'd2, 2'd2, 2'd0};

        //           rst   rv      ordy  sel   rdy     ov    od     src
        tbl[0]  = '{1'b1, 3'b000, 1'b1, 2'd3, 3'b000, 1'b0, 32'h0, 2'd0};
        tbl[1]  = '{1'b0, 3'b000, 1'b1, 2'd3, 3'b000, 1'b0, 32'h0, 2'd0};
        tbl[2]  = '{1'b0, 3'b010, 1'b1, 2'd3, 3'b000, 1'b0, 32'h0, 2'd0};
        tbl[3]  = '{1'b0, 3'b010, 1'b1, 2'd1, 3'b010, 1'b0, 32'h0, 2'd0};
        tbl[4]  = '{1'b0, 3'b000, 1'b1, 2'd1, 3'b010, 1'b1, D1,    2'd1};
        tbl[5]  = '{1'b0, 3'b001, 1'b1, 2'd3, 3'b000, 1'b0, D1,    2'd1};
        tbl[6]  = '{1'b0, 3'b001, 1'b0, 2'd0, 3'b001, 1'b0, D1,    2'd1};
        tbl[7]  = '{1'b0, 3'b001, 1'b0, 2'd0, 3'b000, 1'b1, D0,    2'd0};
        tbl[8]  = '{1'b0, 3'b001, 1'b1, 2'd0, 3'b001, 1'b1, D0,    2'd0};
        tbl[9]  = '{1'b0, 3'b000, 1'b1, 2'd0, 3'b001, 1'b1, D0,    2'd0};
        tbl[10] = '{1'b0, 3'b000, 1'b1, 2'd3, 3'b000, 1'b0, D0,    2'd0};

        for (int i = 0; i < 11; i++) begin
            tick();
            rst       = tbl[i].rst;
            req_valid = tbl[i].rv;
            out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("row%0d sel", i), 32'(sel), 32'(tbl[i].e_sel));
            chk($sformatf("row%0d req_ready", i),
                32'(req_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("row%0d out_valid", i),
                32'(out_valid), 32'(tbl[i].e_ov));
            chk($sformatf("row%0d out_data", i), out_data, tbl[i].e_od);
            chk($sformatf("row%0d out_src", i),
                32'(out_src), 32'(tbl[i].e_src));
        end

        // Idle: ptr left at 1 by the table must survive 10 idle cycles.
        for (int i = 0; i < 10; i++) begin
            tick();
            req_valid = 3'b000;
            #1;
            chk($sformatf("idle%0d sel", i), 32'(sel), 32'd3);
            chk($sformatf("idle%0d out_valid", i), 32'(out_valid), 32'd0);
        end
        tick();
        req_valid = 3'b111;
        #1;
        chk("idle wake sel", 32'(sel), 32'd3);
        tick();
        #1;
        chk("idle ptr grant", 32'(sel), 32'd1);

        // Backpressure mid-burst.
        req_valid = 3'b001;
        out_ready = 1'b1;
        in0       = 32'hB000_0001;
        do_reset();
        tick();
        in0 = 32'hB000_0001;
        #1;
        chk("bp first sel", 32'(sel), 32'd0);
        tick();
        in0 = 32'hB000_0002;
        #1;
        chk("bp word1", out_data, 32'hB000_0001);
        for (int k = 0; k < 5; k++) begin
            tick();
            out_ready = 1'b0;
            in0       = 32'hBAD0_0000 + 32'(k);
            #1;
            chk($sformatf("bp%0d req_ready", k), 32'(req_ready), 32'd0);
            chk($sformatf("bp%0d out_data", k), out_data, 32'hB000_0002);
            chk($sformatf("bp%0d out_valid", k), 32'(out_valid), 32'd1);
        end
        tick();
        out_ready = 1'b1;
        in0       = 32'hB000_0003;
        #1;
        chk("bp resume req_ready", 32'(req_ready), 32'b001);
        tick();
        #1;
        chk("bp resume out_data", out_data, 32'hB000_0003);
        chk("bp resume out_src", 32'(out_src), 32'd0);
        in0 = D0;

        // Early release of requester 2 after two transfers.
        req_valid = 3'b100;
        out_ready = 1'b1;
        do_reset();
        tick();
        #1;
        chk("er grant sel", 32'(sel), 32'd2);
        tick();
        #1;
        chk("er word1 src", 32'(out_src), 32'd2);
        tick();
        req_valid = 3'b011;
        #1;
        chk("er drop sel", 32'(sel), 32'd2);
        chk("er drop out_data", out_data, D2);
        tick();
        #1;
        chk("er idle sel", 32'(sel), 32'd3);
        tick();
        #1;
        chk("er regrant sel", 32'(sel), 32'd0);
        chk("er regrant req_ready", 32'(req_ready), 32'b001);

        // Fairness with BURST=4, rotation with BURST=1.
        req_valid = 3'b111;
        out_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 13; i++) src_log[i] = 2'd3;
        n = 0;
        for (int c = 0; c < 100 && n < 13; c++) begin
            if (c < 8) begin
                chk($sformatf("b1 sel c%0d", c), 32'(b1_sel),
                    32'(b1_exp[c]));
            end
            if (out_valid) begin
                src_log[n] = out_src;
                chk($sformatf("fair data%0d", n), out_data,
                    dsrc(fair_exp[n]));
                n++;
            end
            tick();
            #1;
        end
        chk("fair word count", 32'(n), 32'd13);
        for (int i = 0; i < 13; i++) begin
            chk($sformatf("fair src%0d", i), 32'(src_log[i]),
                32'(fair_exp[i]));
        end

        // Reset in the middle of an active burst.
        chk("mid pre out_valid", 32'(out_valid), 32'd1);
        do_reset();
        chk("mid rst out_valid", 32'(out_valid), 32'd0);
        chk("mid rst sel", 32'(sel), 32'd3);
        chk("mid rst req_ready", 32'(req_ready), 32'd0);
        chk("mid rst out_data", out_data, 32'd0);
        chk("mid rst b1 out_valid", 32'(b1_out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
